// File: rtl/pipe_stage_fifo.sv
// Elastic inter-stage pipeline buffer: DEPTH-entry circular FIFO with valid/ready handshake and single-cycle flush.
// Define PIPE_STAGE_FIFO_BYPASS_EN to let an empty buffer pass the input straight through combinationally.
module pipe_stage_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       almost_full_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             has_data, bypass, push, pop;

    // Explicit wrap keeps non-power-of-two depths correct without a modulo.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign has_data = (count_q != '0);

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
    assign bypass = !has_data && in_valid_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready_o    = (count_q != CW'(DEPTH));
    assign push          = in_valid_i && in_ready_o && !flush_i && !(bypass && out_ready_i);
    assign pop           = has_data && out_ready_i && !flush_i;
    assign out_valid_o   = has_data || bypass;
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CW'(AFULL_LVL));

    always_comb begin
        out_data_o = '0;
        if (has_data) begin
            out_data_o = mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_data_o = in_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = advance(wr_ptr_q);
            if (pop)  rd_ptr_d = advance(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Flush leaves stale payloads in mem; only reset scrubs the storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed self-checking bench for pipe_stage_fifo: a DEPTH=4 instance and a DEPTH=3 instance for the wrap test.
// Expectations follow PIPE_STAGE_FIFO_BYPASS_EN when the bypass test is reached.
module tb_pipe_stage_fifo;

    logic clk = 1'b0;
    logic rst;

    logic        aFlush, aInValid, aInReady, aOutValid, aOutReady, aAlmostFull;
    logic [31:0] aInData, aOutData;
    logic [2:0]  aCount;

    logic        bFlush, bInValid, bInReady, bOutValid, bOutReady, bAlmostFull;
    logic [31:0] bInData, bOutData;
    logic [1:0]  bCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(4)) uDepth4 (
        .clk(clk), .rst(rst), .flush_i(aFlush),
        .in_valid_i(aInValid), .in_ready_o(aInReady), .in_data_i(aInData),
        .out_valid_o(aOutValid), .out_ready_i(aOutReady), .out_data_o(aOutData),
        .count_o(aCount), .almost_full_o(aAlmostFull)
    );

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(3)) uDepth3 (
        .clk(clk), .rst(rst), .flush_i(bFlush),
        .in_valid_i(bInValid), .in_ready_o(bInReady), .in_data_i(bInData),
        .out_valid_o(bOutValid), .out_ready_i(bOutReady), .out_data_o(bOutData),
        .count_o(bCount), .almost_full_o(bAlmostFull)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and settle just past the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin : mainSeq
        int sent;
        int recvd;
        int cyc;
        logic [4:0] readyPattern;

        readyPattern = 5'b01101;

        rst = 1'b1;
        aFlush = 1'b0; aInValid = 1'b1; aInData = 32'hDEADBEEF; aOutReady = 1'b0;
        bFlush = 1'b0; bInValid = 1'b1; bInData = 32'hDEADBEEF; bOutReady = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        aInValid = 1'b0;
        bInValid = 1'b0;
        #1;
        checkOutput("rst_count",     32'(aCount),      32'd0);
        checkOutput("rst_out_valid", 32'(aOutValid),   32'd0);
        checkOutput("rst_out_data",  aOutData,         32'd0);
        checkOutput("rst_in_ready",  32'(aInReady),    32'd1);
        checkOutput("rst_afull",     32'(aAlmostFull), 32'd0);
        checkOutput("rst_b_count",   32'(bCount),      32'd0);

        // Fill to full with the consumer stalled.
        aInValid = 1'b1; aInData = 32'h10;
        applyStimulus();
        checkOutput("fill_count1", 32'(aCount), 32'd1);
        checkOutput("fill_head1",  aOutData,    32'h10);
        aInData = 32'h11;
        applyStimulus();
        checkOutput("fill_count2", 32'(aCount),      32'd2);
        checkOutput("fill_afull2", 32'(aAlmostFull), 32'd0);
        aInData = 32'h12;
        applyStimulus();
        checkOutput("fill_count3", 32'(aCount),      32'd3);
        checkOutput("fill_afull3", 32'(aAlmostFull), 32'd1);
        aInData = 32'h13;
        applyStimulus();
        checkOutput("fill_count4",   32'(aCount),   32'd4);
        checkOutput("fill_in_ready", 32'(aInReady), 32'd0);
        aInData = 32'h99;
        applyStimulus();
        checkOutput("overfill_count", 32'(aCount), 32'd4);
        checkOutput("overfill_head",  aOutData,    32'h10);

        // Drain one payload per cycle in arrival order.
        aInValid = 1'b0; aOutReady = 1'b1;
        applyStimulus();
        checkOutput("drain_head11", aOutData,    32'h11);
        checkOutput("drain_count3", 32'(aCount), 32'd3);
        applyStimulus();
        checkOutput("drain_head12", aOutData, 32'h12);
        applyStimulus();
        checkOutput("drain_head13", aOutData, 32'h13);
        applyStimulus();
        checkOutput("drain_empty_valid", 32'(aOutValid), 32'd0);
        checkOutput("drain_empty_data",  aOutData,       32'd0);
        checkOutput("drain_empty_count", 32'(aCount),    32'd0);

        // Simultaneous push and pop at count=2.
        aOutReady = 1'b0; aInValid = 1'b1; aInData = 32'h20;
        applyStimulus();
        aInData = 32'h21;
        applyStimulus();
        checkOutput("pp_pre_count", 32'(aCount), 32'd2);
        checkOutput("pp_pre_head",  aOutData,    32'h20);
        aInData = 32'hAA; aOutReady = 1'b1;
        applyStimulus();
        checkOutput("pp_count", 32'(aCount), 32'd2);
        checkOutput("pp_head",  aOutData,    32'h21);
        aInValid = 1'b0;
        applyStimulus();
        checkOutput("pp_head_aa", aOutData, 32'hAA);
        applyStimulus();
        checkOutput("pp_empty", 32'(aCount), 32'd0);

        // Flush with three entries held and a payload on the input.
        aOutReady = 1'b0; aInValid = 1'b1;
        aInData = 32'h30; applyStimulus();
        aInData = 32'h31; applyStimulus();
        aInData = 32'h32; applyStimulus();
        checkOutput("fl_pre_count", 32'(aCount), 32'd3);
        aFlush = 1'b1; aInData = 32'h55;
        applyStimulus();
        aFlush = 1'b0; aInValid = 1'b0;
        checkOutput("fl_count", 32'(aCount),    32'd0);
        checkOutput("fl_valid", 32'(aOutValid), 32'd0);
        checkOutput("fl_data",  aOutData,       32'd0);
        aOutReady = 1'b1;
        applyStimulus();
        checkOutput("fl_no55_valid", 32'(aOutValid), 32'd0);
        aOutReady = 1'b0; aInValid = 1'b1; aInData = 32'h66;
        applyStimulus();
        aInValid = 1'b0;
        checkOutput("fl_repush_count", 32'(aCount), 32'd1);
        checkOutput("fl_repush_head",  aOutData,    32'h66);
        aOutReady = 1'b1;
        applyStimulus();
        checkOutput("fl_repush_empty", 32'(aCount), 32'd0);

        // Empty buffer presented with a payload and a ready consumer.
        aInValid = 1'b1; aInData = 32'h77; aOutReady = 1'b1;
        #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        checkOutput("byp_same_valid", 32'(aOutValid), 32'd1);
        checkOutput("byp_same_data",  aOutData,       32'h77);
`else
        checkOutput("byp_same_valid", 32'(aOutValid), 32'd0);
        checkOutput("byp_same_data",  aOutData,       32'd0);
`endif
        applyStimulus();
        aInValid = 1'b0;
        #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        checkOutput("byp_next_count", 32'(aCount),    32'd0);
        checkOutput("byp_next_valid", 32'(aOutValid), 32'd0);
`else
        checkOutput("byp_next_count", 32'(aCount),    32'd1);
        checkOutput("byp_next_data",  aOutData,       32'h77);
`endif
        applyStimulus();
        checkOutput("byp_final_count", 32'(aCount), 32'd0);

        // Stream 0..9 through DEPTH=3 with a toggling consumer across pointer wrap.
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 10 && cyc < 200) begin
            bInValid  = (sent < 10);
            bInData   = 32'(sent);
            bOutReady = readyPattern[cyc % 5];
            #1;
            if (bOutValid && bOutReady) begin
                checkOutput("wrap_order", bOutData, 32'(recvd));
                recvd++;
            end
            if (bInValid && bInReady) sent++;
            applyStimulus();
            cyc++;
        end
        bInValid = 1'b0; bOutReady = 1'b0;
        checkOutput("wrap_received", 32'(recvd), 32'd10);
        #1;
        checkOutput("wrap_empty", 32'(bCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
